// File: rtl/core_pkg.sv
// Shared core types: writeback bundle, arbiter mode, register constants.
// Imported by pipeline-side units that touch the integer register file.
package core_pkg;

  localparam int CORE_XLEN = 64;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           rd;
    logic [CORE_XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PIPE_PRIO = 1'b0,
    MD_PRIO   = 1'b1
  } wb_mode_e;

endpackage

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline vs mul/div writeback.
// Pipeline has default priority; a starvation counter forces mul/div through.
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid_i,
  output logic            pipe_ready_o,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_data_i,
  output logic            rd_wen_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [3:0]      starve_cnt_o
);

  import core_pkg::*;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_mode_e        mode_q, mode_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wen_q, wen_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;

  logic pipe_x0, md_x0;
  logic pipe_nz, md_nz;
  logic pipe_gnt, md_gnt;

  assign pipe_x0 = pipe_valid_i && (pipe_rd_i == REG_X0);
  assign md_x0   = md_valid_i && (md_rd_i == REG_X0);
  assign pipe_nz = pipe_valid_i && (pipe_rd_i != REG_X0);
  assign md_nz   = md_valid_i && (md_rd_i != REG_X0);

  // Grant selection: at most one non-x0 winner per cycle.
  always_comb begin
    pipe_gnt = 1'b0;
    md_gnt   = 1'b0;
    unique case (mode_q)
      PIPE_PRIO: begin
        pipe_gnt = pipe_nz;
        md_gnt   = md_nz && !pipe_nz;
      end
      MD_PRIO: begin
        md_gnt   = md_nz;
        pipe_gnt = 1'b0;
      end
      default: begin
        pipe_gnt = 1'b0;
        md_gnt   = 1'b0;
      end
    endcase
  end

  // x0 writes are acknowledged and dropped without using the slot.
  assign pipe_ready_o = pipe_x0 || pipe_gnt;
  assign md_ready_o   = md_x0 || md_gnt;

  // Starvation counter and mode next-state.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (md_gnt) begin
      cnt_d = 4'd0;
    end else if (md_nz && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 4'd1;
    end
    unique case (mode_q)
      PIPE_PRIO: begin
        if (cnt_d == LIMIT) mode_d = MD_PRIO;
      end
      MD_PRIO: begin
        if (md_gnt) begin
          mode_d = PIPE_PRIO;
        end else if (!md_nz) begin
          mode_d = PIPE_PRIO;
          cnt_d  = 4'd0;
        end
      end
      default: begin
        mode_d = PIPE_PRIO;
        cnt_d  = 4'd0;
      end
    endcase
  end

  // Write-port next value: address/data hold when idle.
  always_comb begin
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (1'b1)
      pipe_gnt: begin
        wen_d  = 1'b1;
        addr_d = pipe_rd_i;
        data_d = pipe_data_i;
      end
      md_gnt: begin
        wen_d  = 1'b1;
        addr_d = md_rd_i;
        data_d = md_data_i;
      end
      default: begin
        wen_d = 1'b0;
      end
    endcase
  end

  // State and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= PIPE_PRIO;
      cnt_q  <= 4'd0;
      wen_q  <= 1'b0;
      addr_q <= 5'd0;
      data_q <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rd_wen_o     = wen_q;
  assign rd_addr_o    = addr_q;
  assign rd_data_o    = data_q;
  assign starve_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued at the
// handshake and popped one cycle later against the register-file port.
module tb_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_valid_i = 1'b0;
  logic            pipe_ready_o;
  logic [4:0]      pipe_rd_i = '0;
  logic [XLEN-1:0] pipe_data_i = '0;
  logic            md_valid_i = 1'b0;
  logic            md_ready_o;
  logic [4:0]      md_rd_i = '0;
  logic [XLEN-1:0] md_data_i = '0;
  logic            rd_wen_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic [3:0]      starve_cnt_o;

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_valid_i (pipe_valid_i),
    .pipe_ready_o (pipe_ready_o),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .md_valid_i   (md_valid_i),
    .md_ready_o   (md_ready_o),
    .md_rd_i      (md_rd_i),
    .md_data_i    (md_data_i),
    .rd_wen_o     (rd_wen_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .starve_cnt_o (starve_cnt_o)
  );

  task automatic drive(input logic pv, input logic [4:0] prd,
                       input logic [XLEN-1:0] pd, input logic mv,
                       input logic [4:0] mrd, input logic [XLEN-1:0] md);
    pipe_valid_i = pv;
    pipe_rd_i    = prd;
    pipe_data_i  = pd;
    md_valid_i   = mv;
    md_rd_i      = mrd;
    md_data_i    = md;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    #1;
    checks++;
    if (rd_wen_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== '0 ||
        starve_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL reset: wen=%b addr=%0d data=%h cnt=%0d want 0/0/0/0",
               rd_wen_o, rd_addr_o, rd_data_o, starve_cnt_o);
    end
    e.a = 0;
    e.d = 0;
  endtask

  task automatic test_pipe_only();
    exp_t e;
    @(negedge clk);
    drive(1, 5, 64'hAAAA, 0, 0, 0);
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1 || md_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL pipe_only_ready: pr=%b mr=%b want 1/0",
               pipe_ready_o, md_ready_o);
    end
    sbq.push_back('{a: 5, d: 64'hAAAA});
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    e = sbq.pop_front();
    checks++;
    if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || rd_data_o !== e.d) begin
      failures++;
      $display("FAIL pipe_only_write: wen=%b addr=%0d data=%h want 1/%0d/%h",
               rd_wen_o, rd_addr_o, rd_data_o, e.a, e.d);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_wen_o !== 1'b0) begin
      failures++;
      $display("FAIL pipe_only_idle: wen=%b want 0", rd_wen_o);
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    logic       exp_md;
    logic [3:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      drive(1, 3, 64'h100 + 64'(i), 1, 7, 64'h200 + 64'(i));
      #1;
      exp_md = (i == 5);
      checks++;
      if (pipe_ready_o !== !exp_md || md_ready_o !== exp_md) begin
        failures++;
        $display("FAIL starve_ready[%0d]: pr=%b mr=%b want %b/%b",
                 i, pipe_ready_o, md_ready_o, !exp_md, exp_md);
      end
      if (exp_md) sbq.push_back('{a: 7, d: 64'h200 + 64'(i)});
      else        sbq.push_back('{a: 3, d: 64'h100 + 64'(i)});
      exp_cnt = (i <= 4) ? 4'(i) : (i == 5) ? 4'd0 : 4'd1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      checks++;
      if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || rd_data_o !== e.d ||
          starve_cnt_o !== exp_cnt) begin
        failures++;
        $display("FAIL starve_out[%0d]: wen=%b addr=%0d data=%h cnt=%0d want 1/%0d/%h/%0d",
                 i, rd_wen_o, rd_addr_o, rd_data_o, starve_cnt_o,
                 e.a, e.d, exp_cnt);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_x0_pair();
    exp_t e;
    do_reset();
    @(negedge clk);
    drive(1, 0, 64'hDEAD, 1, 9, 64'h1234);
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1 || md_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL x0_pair_ready: pr=%b mr=%b want 1/1",
               pipe_ready_o, md_ready_o);
    end
    sbq.push_back('{a: 9, d: 64'h1234});
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    e = sbq.pop_front();
    checks++;
    if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || rd_data_o !== e.d ||
        starve_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL x0_pair_write: wen=%b addr=%0d data=%h cnt=%0d want 1/%0d/%h/0",
               rd_wen_o, rd_addr_o, rd_data_o, starve_cnt_o, e.a, e.d);
    end
  endtask

  task automatic test_both_x0();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      drive(1, 4, 64'h40 + 64'(i), 1, 6, 64'h60);
      sbq.push_back('{a: 4, d: 64'h40 + 64'(i)});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      checks++;
      if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || rd_data_o !== e.d ||
          starve_cnt_o !== 4'(i)) begin
        failures++;
        $display("FAIL both_x0_pre[%0d]: wen=%b addr=%0d cnt=%0d want 1/%0d/%0d",
                 i, rd_wen_o, rd_addr_o, starve_cnt_o, e.a, i);
      end
    end
    @(negedge clk);
    drive(1, 0, 64'h1, 1, 0, 64'h2);
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1 || md_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL both_x0_ready: pr=%b mr=%b want 1/1",
               pipe_ready_o, md_ready_o);
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (rd_wen_o !== 1'b0 || starve_cnt_o !== 4'd2 || sbq.size() != 0) begin
      failures++;
      $display("FAIL both_x0_out: wen=%b cnt=%0d q=%0d want 0/2/0",
               rd_wen_o, starve_cnt_o, sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(1, 2, 64'h20 + 64'(i), 1, 8, 64'h80);
      sbq.push_back('{a: 2, d: 64'h20 + 64'(i)});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      checks++;
      if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || starve_cnt_o !== 4'(i)) begin
        failures++;
        $display("FAIL reset_mid_pre[%0d]: wen=%b addr=%0d cnt=%0d want 1/%0d/%0d",
                 i, rd_wen_o, rd_addr_o, starve_cnt_o, e.a, i);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_wen_o !== 1'b0 || starve_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_async: wen=%b cnt=%0d want 0/0",
               rd_wen_o, starve_cnt_o);
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2, 64'h99, 1, 8, 64'h80);
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1 || md_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ready: pr=%b mr=%b want 1/0",
               pipe_ready_o, md_ready_o);
    end
    sbq.push_back('{a: 2, d: 64'h99});
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    e = sbq.pop_front();
    checks++;
    if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || rd_data_o !== e.d ||
        starve_cnt_o !== 4'd1) begin
      failures++;
      $display("FAIL reset_mid_after: wen=%b addr=%0d data=%h cnt=%0d want 1/%0d/%h/1",
               rd_wen_o, rd_addr_o, rd_data_o, starve_cnt_o, e.a, e.d);
    end
  endtask

  task automatic test_md_alone();
    exp_t e;
    do_reset();
    @(negedge clk);
    drive(0, 0, 0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    checks++;
    if (md_ready_o !== 1'b1 || pipe_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL md_alone_ready: mr=%b pr=%b want 1/0",
               md_ready_o, pipe_ready_o);
    end
    sbq.push_back('{a: 31, d: 64'hFFFF_FFFF_FFFF_FFFF});
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    e = sbq.pop_front();
    checks++;
    if (rd_wen_o !== 1'b1 || rd_addr_o !== e.a || rd_data_o !== e.d ||
        starve_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL md_alone_write: wen=%b addr=%0d data=%h cnt=%0d want 1/%0d/%h/0",
               rd_wen_o, rd_addr_o, rd_data_o, starve_cnt_o, e.a, e.d);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_wen_o !== 1'b0) begin
      failures++;
      $display("FAIL md_alone_idle: wen=%b want 0", rd_wen_o);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_starvation();
    test_x0_pair();
    test_both_x0();
    test_reset_mid();
    test_md_alone();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
